// File: rtl/neoprof_access_arbiter.sv
// Merges sampled read/write page-address streams into one push port with
// per-source buffering, round-robin arbitration, epoch ticks and drop counting.
module neoprof_access_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  afu_clk,
  input  logic                  afu_rstn,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] rd_req_page,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] wr_req_page,
  input  logic                  push_ready,
  output logic                  push_en,
  output logic [ADDR_WIDTH-1:0] push_data,
  output logic                  push_is_write,
  input  logic                  cfg_enable,
  input  logic                  cfg_wr_enable,
  input  logic [3:0]            cfg_sample_log2,
  input  logic [31:0]           cfg_epoch_len,
  output logic                  epoch_tick,
  output logic [15:0]           drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Index 0 is the read stream, index 1 the write stream.
  logic [ADDR_WIDTH-1:0] fifo_mem_r [2][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r   [2];
  logic [PTR_W-1:0]      rd_ptr_r   [2];
  logic [CNT_W-1:0]      fifo_cnt_r [2];
  logic [15:0]           samp_cnt_r [2];
  logic                  rr_last_r;
  logic                  push_en_r;
  logic [ADDR_WIDTH-1:0] push_data_r;
  logic                  push_is_write_r;
  logic [31:0]           epoch_cnt_r;
  logic                  epoch_tick_r;
  logic [15:0]           drop_cnt_r;

  logic [ADDR_WIDTH-1:0] req_page_s [2];
  logic [1:0]            qual_s;
  logic [1:0]            sampled_s;
  logic [1:0]            full_s;
  logic [1:0]            nonempty_s;
  logic [1:0]            enq_s;
  logic [1:0]            drop_s;
  logic [1:0]            pop_s;
  logic [15:0]           sample_mask_s;
  logic                  grant_any_s;
  logic                  grant_src_s;
  logic [ADDR_WIDTH-1:0] head_s;
  logic [1:0]            drop_inc_s;
  logic [16:0]           drop_sum_s;
  logic [31:0]           epoch_last_s;
  logic                  epoch_wrap_s;

  // Qualification, sampling decision and full/empty status per source.
  always_comb begin
    qual_s[0]     = rd_req_valid & cfg_enable;
    qual_s[1]     = wr_req_valid & cfg_enable & cfg_wr_enable;
    req_page_s[0] = rd_req_page;
    req_page_s[1] = wr_req_page;
    sample_mask_s = (16'd1 << cfg_sample_log2) - 16'd1;
    for (int i = 0; i < 2; i++) begin
      sampled_s[i]  = qual_s[i] & ((samp_cnt_r[i] & sample_mask_s) == 16'd0);
      // Full is taken before any same-cycle pop, so a full buffer drops.
      full_s[i]     = (fifo_cnt_r[i] == FULL_CNT);
      nonempty_s[i] = (fifo_cnt_r[i] != CNT_ZERO);
      enq_s[i]      = sampled_s[i] & ~full_s[i];
      drop_s[i]     = sampled_s[i] & full_s[i];
    end
  end

  // Round-robin grant between the two buffers under backpressure.
  always_comb begin
    grant_any_s = 1'b0;
    grant_src_s = 1'b0;
    pop_s       = 2'b00;
    if (push_ready) begin
      case (nonempty_s)
        2'b11: begin
          grant_any_s = 1'b1;
          grant_src_s = ~rr_last_r;
        end
        2'b01: begin
          grant_any_s = 1'b1;
          grant_src_s = 1'b0;
        end
        2'b10: begin
          grant_any_s = 1'b1;
          grant_src_s = 1'b1;
        end
        default: begin
          grant_any_s = 1'b0;
          grant_src_s = 1'b0;
        end
      endcase
    end else begin
      grant_any_s = 1'b0;
      grant_src_s = 1'b0;
    end
    if (grant_any_s) begin
      pop_s[grant_src_s] = 1'b1;
    end else begin
      pop_s = 2'b00;
    end
    head_s = fifo_mem_r[grant_src_s][rd_ptr_r[grant_src_s]];
  end

  // Drop increment with saturation headroom, and epoch boundary detect.
  always_comb begin
    drop_inc_s   = {1'b0, drop_s[0]} + {1'b0, drop_s[1]};
    drop_sum_s   = {1'b0, drop_cnt_r} + {15'd0, drop_inc_s};
    epoch_last_s = cfg_epoch_len - 32'd1;
    epoch_wrap_s = (epoch_cnt_r >= epoch_last_s);
  end

  // Per-source buffers and sample counters.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          fifo_mem_r[i][j] <= {ADDR_WIDTH{1'b0}};
        end
        wr_ptr_r[i]   <= PTR_ZERO;
        rd_ptr_r[i]   <= PTR_ZERO;
        fifo_cnt_r[i] <= CNT_ZERO;
        samp_cnt_r[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (enq_s[i]) begin
          fifo_mem_r[i][wr_ptr_r[i]] <= req_page_s[i];
          wr_ptr_r[i]                <= wr_ptr_r[i] + PTR_ONE;
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
        end
        fifo_cnt_r[i] <= fifo_cnt_r[i] + (enq_s[i] ? CNT_ONE : CNT_ZERO)
                                       - (pop_s[i] ? CNT_ONE : CNT_ZERO);
        if (qual_s[i]) begin
          samp_cnt_r[i] <= samp_cnt_r[i] + 16'd1;
        end
      end
    end
  end

  // Registered push port and round-robin history.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      rr_last_r       <= 1'b1;
      push_en_r       <= 1'b0;
      push_data_r     <= {ADDR_WIDTH{1'b0}};
      push_is_write_r <= 1'b0;
    end else begin
      push_en_r <= grant_any_s;
      if (grant_any_s) begin
        rr_last_r       <= grant_src_s;
        push_data_r     <= head_s;
        push_is_write_r <= grant_src_s;
      end
    end
  end

  // Epoch counter/tick and per-epoch saturating drop counter.
  always_ff @(posedge afu_clk or negedge afu_rstn) begin
    if (!afu_rstn) begin
      epoch_cnt_r  <= 32'd0;
      epoch_tick_r <= 1'b0;
      drop_cnt_r   <= 16'd0;
    end else begin
      if (cfg_epoch_len == 32'd0) begin
        epoch_cnt_r  <= 32'd0;
        epoch_tick_r <= 1'b0;
      end else if (cfg_enable) begin
        if (epoch_wrap_s) begin
          epoch_cnt_r  <= 32'd0;
          epoch_tick_r <= 1'b1;
        end else begin
          epoch_cnt_r  <= epoch_cnt_r + 32'd1;
          epoch_tick_r <= 1'b0;
        end
      end else begin
        epoch_tick_r <= 1'b0;
      end
      if (epoch_tick_r) begin
        drop_cnt_r <= {14'd0, drop_inc_s};
      end else if (drop_sum_s[16]) begin
        drop_cnt_r <= 16'hFFFF;
      end else begin
        drop_cnt_r <= drop_sum_s[15:0];
      end
    end
  end

  assign push_en       = push_en_r;
  assign push_data     = push_data_r;
  assign push_is_write = push_is_write_r;
  assign epoch_tick    = epoch_tick_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_neoprof_access_arbiter.sv
// Directed, table-driven bench for neoprof_access_arbiter.
module tb_neoprof_access_arbiter;

  localparam int AW = 32;

  logic          afu_clk = 1'b0;
  logic          afu_rstn;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_page;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_page;
  logic          push_ready;
  logic          push_en;
  logic [AW-1:0] push_data;
  logic          push_is_write;
  logic          cfg_enable;
  logic          cfg_wr_enable;
  logic [3:0]    cfg_sample_log2;
  logic [31:0]   cfg_epoch_len;
  logic          epoch_tick;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rd_v;
    logic [AW-1:0] rd_p;
    logic          wr_v;
    logic [AW-1:0] wr_p;
    logic          rdy;
    logic          exp_en;
    logic [AW-1:0] exp_data;
    logic          exp_w;
  } vec_t;

  vec_t tbl [15];
  logic [AW:0] pushes [$];

  neoprof_access_arbiter #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .afu_clk(afu_clk), .afu_rstn(afu_rstn),
    .rd_req_valid(rd_req_valid), .rd_req_page(rd_req_page),
    .wr_req_valid(wr_req_valid), .wr_req_page(wr_req_page),
    .push_ready(push_ready), .push_en(push_en), .push_data(push_data),
    .push_is_write(push_is_write), .cfg_enable(cfg_enable),
    .cfg_wr_enable(cfg_wr_enable), .cfg_sample_log2(cfg_sample_log2),
    .cfg_epoch_len(cfg_epoch_len), .epoch_tick(epoch_tick), .drop_cnt(drop_cnt)
  );

  always #5 afu_clk = ~afu_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge afu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req_valid = 1'b0;
    rd_req_page  = 32'h0;
    wr_req_valid = 1'b0;
    wr_req_page  = 32'h0;
  endtask

  task automatic do_reset();
    afu_rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge afu_clk);
    #1;
    afu_rstn = 1'b1;
    pushes.delete();
  endtask

  task automatic record_push();
    if (push_en) pushes.push_back({push_is_write, push_data});
  endtask

  function automatic logic [31:0] push_at(input int i);
    if (i < pushes.size()) return {1'b0, pushes[i][30:0]} | {pushes[i][32], 31'h0} & 32'h0 | pushes[i][31:0];
    return 32'hDEADBEEF;
  endfunction

  initial begin
    afu_rstn        = 1'b0;
    push_ready      = 1'b1;
    cfg_enable      = 1'b1;
    cfg_wr_enable   = 1'b1;
    cfg_sample_log2 = 4'd0;
    cfg_epoch_len   = 32'd0;
    idle_inputs();
    #2;
    check("rst_push_en", {31'h0, push_en}, 32'h0);
    check("rst_push_data", push_data, 32'h0);
    check("rst_is_write", {31'h0, push_is_write}, 32'h0);
    check("rst_tick", {31'h0, epoch_tick}, 32'h0);
    check("rst_drop", {16'h0, drop_cnt}, 32'h0);

    // Single read: latency of exactly two cycles.
    do_reset();
    rd_req_valid = 1'b1; rd_req_page = 32'h1234;
    check("lat_c0_en", {31'h0, push_en}, 32'h0);
    next_cycle(); idle_inputs();
    check("lat_c1_en", {31'h0, push_en}, 32'h0);
    next_cycle();
    check("lat_c2_en", {31'h0, push_en}, 32'h1);
    check("lat_c2_data", push_data, 32'h1234);
    check("lat_c2_w", {31'h0, push_is_write}, 32'h0);
    next_cycle();
    check("lat_c3_en", {31'h0, push_en}, 32'h0);
    check("lat_c3_hold", push_data, 32'h1234);

    // Both streams saturated: strict R,W alternation starting with the read.
    for (int c = 0; c < 15; c++) begin
      int k;
      k = c - 2;
      tbl[c].rd_v     = (c < 6);
      tbl[c].rd_p     = 32'h10 + 32'(c);
      tbl[c].wr_v     = (c < 6);
      tbl[c].wr_p     = 32'h20 + 32'(c);
      tbl[c].rdy      = 1'b1;
      tbl[c].exp_en   = (c >= 2) && (c <= 13);
      tbl[c].exp_data = (k % 2 == 0) ? 32'h10 + 32'(k / 2) : 32'h20 + 32'(k / 2);
      tbl[c].exp_w    = (k % 2 == 1);
    end
    do_reset();
    for (int c = 0; c < 15; c++) begin
      rd_req_valid = tbl[c].rd_v; rd_req_page = tbl[c].rd_p;
      wr_req_valid = tbl[c].wr_v; wr_req_page = tbl[c].wr_p;
      push_ready   = tbl[c].rdy;
      check($sformatf("alt_en[%0d]", c), {31'h0, push_en}, {31'h0, tbl[c].exp_en});
      if (tbl[c].exp_en) begin
        check($sformatf("alt_data[%0d]", c), push_data, tbl[c].exp_data);
        check($sformatf("alt_w[%0d]", c), {31'h0, push_is_write}, {31'h0, tbl[c].exp_w});
      end
      next_cycle();
    end
    idle_inputs();
    check("alt_drop", {16'h0, drop_cnt}, 32'h0);

    // Sampling 1 of 4: pages 0, 4 and 8 survive.
    do_reset();
    cfg_sample_log2 = 4'd2;
    for (int c = 0; c < 13; c++) begin
      rd_req_valid = (c <= 8); rd_req_page = 32'(c);
      record_push();
      next_cycle();
    end
    idle_inputs();
    cfg_sample_log2 = 4'd0;
    check("samp_count", pushes.size(), 32'd3);
    check("samp_p0", push_at(0), 32'h0);
    check("samp_p1", push_at(1), 32'h4);
    check("samp_p2", push_at(2), 32'h8);

    // Backpressure: buffer fills, extra reads drop, including one arriving on a pop.
    do_reset();
    push_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rd_req_valid = 1'b1; rd_req_page = 32'(c);
      record_push();
      next_cycle();
    end
    record_push();
    check("bp_no_push", pushes.size(), 32'd0);
    check("bp_drop2", {16'h0, drop_cnt}, 32'h2);
    push_ready = 1'b1; rd_req_page = 32'h99;
    next_cycle();
    idle_inputs();
    check("bp_drop_on_pop", {16'h0, drop_cnt}, 32'h3);
    for (int c = 0; c < 8; c++) begin
      record_push();
      next_cycle();
    end
    check("bp_drain_count", pushes.size(), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("bp_drain[%0d]", i), push_at(i), 32'(i));

    // Simultaneous drops on both sources add two in one cycle.
    do_reset();
    push_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rd_req_valid = 1'b1; rd_req_page = 32'(c);
      wr_req_valid = 1'b1; wr_req_page = 32'h100 + 32'(c);
      if (c == 4) check("dual_drop_before", {16'h0, drop_cnt}, 32'h0);
      next_cycle();
    end
    idle_inputs();
    check("dual_drop_after", {16'h0, drop_cnt}, 32'h2);

    // Epoch ticks every 5 cycles; drop count restarts at each tick.
    cfg_enable = 1'b0;
    cfg_epoch_len = 32'd5;
    do_reset();
    push_ready = 1'b0;
    for (int c = 0; c < 17; c++) begin
      cfg_enable = 1'b1;
      rd_req_valid = (c <= 5); rd_req_page = 32'(c);
      check($sformatf("tick[%0d]", c), {31'h0, epoch_tick}, {31'h0, (c == 5) || (c == 10) || (c == 15)});
      if (c == 5)  check("ep_drop_c5", {16'h0, drop_cnt}, 32'h1);
      if (c == 6)  check("ep_drop_c6", {16'h0, drop_cnt}, 32'h1);
      if (c == 11) check("ep_drop_c11", {16'h0, drop_cnt}, 32'h0);
      next_cycle();
    end
    idle_inputs();
    cfg_epoch_len = 32'd0;
    begin
      int ticks;
      ticks = 0;
      for (int c = 0; c < 12; c++) begin
        if (epoch_tick) ticks++;
        next_cycle();
      end
      check("ep_len0_ticks", ticks, 32'd0);
    end

    // Asynchronous reset mid-cycle discards queued entries.
    do_reset();
    push_ready = 1'b1;
    wr_req_valid = 1'b1; wr_req_page = 32'h55;
    next_cycle(); idle_inputs();
    next_cycle();
    check("ar_push_w", {31'h0, push_is_write}, 32'h1);
    check("ar_push_data", push_data, 32'h55);
    push_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rd_req_valid = 1'b1; rd_req_page = 32'hA + 32'(c);
      next_cycle();
    end
    idle_inputs();
    check("ar_hold_data", push_data, 32'h55);
    #3;
    afu_rstn = 1'b0;
    #1;
    check("ar_en", {31'h0, push_en}, 32'h0);
    check("ar_data", push_data, 32'h0);
    check("ar_w", {31'h0, push_is_write}, 32'h0);
    @(posedge afu_clk); #1;
    afu_rstn = 1'b1;
    push_ready = 1'b1;
    pushes.delete();
    for (int c = 0; c < 8; c++) begin
      record_push();
      next_cycle();
    end
    check("ar_no_push", pushes.size(), 32'd0);

    // Unqualified requests touch nothing, including the sample counters.
    do_reset();
    cfg_sample_log2 = 4'd1;
    cfg_wr_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wr_req_valid = 1'b1; wr_req_page = 32'h300 + 32'(c);
      record_push();
      next_cycle();
    end
    cfg_wr_enable = 1'b1;
    cfg_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rd_req_valid = 1'b1; rd_req_page = 32'h400 + 32'(c);
      record_push();
      next_cycle();
    end
    idle_inputs();
    cfg_enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      record_push();
      next_cycle();
    end
    check("unq_no_push", pushes.size(), 32'd0);
    rd_req_valid = 1'b1; rd_req_page = 32'h77;
    next_cycle(); idle_inputs();
    for (int c = 0; c < 3; c++) begin
      record_push();
      next_cycle();
    end
    check("unq_then_count", pushes.size(), 32'd1);
    check("unq_then_data", push_at(0), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
